sal_sched_rr: RTL and testbench
===============================

SAL_SCHED_RR -- requirements
Module: sal_sched_rr

Interface
REQ-001 SHALL have parameters: BK_CNT, default 16, number of bank request channels (2..32); RA_W, default 16, row address width; CA_W, default 10, column address width; ID_W, default 4, AXI ID width; LEN_W, default 4, AXI length width; TW, default 6, width of every timing value and counter.
REQ-002 SHALL use one clock and one reset: reset is asynchronous and active-high.
REQ-003 Ports (name  direction  width  meaning): clk  in  1  clock; rst  in  1  async active-high reset.
REQ-004 act_req/rd_req/wr_req/pre_req/ref_req  in  BK_CNT each  per-bank command requests.
REQ-005 ra_arr  in  BK_CNT*RA_W; ca_arr  in  BK_CNT*CA_W; id_arr  in  BK_CNT*ID_W; len_arr  in  BK_CNT*LEN_W  per-bank packed fields, bank i at slice i.
REQ-006 act_gnt/rd_gnt/wr_gnt/pre_gnt/ref_gnt  out  BK_CNT each  per-bank one-hot grants.
REQ-007 cmd_valid  out  1; cmd_type  out  3 (sal_sched_pkg::cmd_t); cmd_ba  out  $clog2(BK_CNT); cmd_ra  out  RA_W; cmd_ca  out  CA_W; cmd_id  out  ID_W; cmd_len  out  LEN_W  registered issued command.
REQ-008 t_rrd_m1, t_ccd_m1, t_rtw_m1, t_wtr_m1, t_faw_m1  in  TW each  timing values minus one; cas_first  in  1  priority mode.

Function
REQ-009 At most one grant bit SHALL be high per cycle across all five grant vectors; grants SHALL be combinational from requests and timer state.
REQ-010 Eligibility: ACT needs rrd_zero and faw_ok; RD needs ccd_zero and wtr_zero; WR needs ccd_zero and rtw_zero; PRE always; REF needs rrd_zero.
REQ-011 cas_first=0: class priority ACT > RD > WR > PRE > REF; cas_first=1: RD > WR > ACT > PRE > REF; only eligible classes with a request compete.
REQ-012 Within a class, arbitration SHALL be round-robin: search starts at bank ptr[c]+1 mod BK_CNT; on grant ptr[c] <= granted bank; ptr of other classes unchanged.
REQ-013 Each ptr[c] SHALL reset to BK_CNT-1 so first search starts at bank 0.
REQ-014 On a grant, the cycle after, cmd_valid=1 and cmd_* SHALL carry type, bank and that bank's fields (ra for ACT, ca/id/len for RD/WR, others zero); cmd_valid=0 otherwise and cmd_* fields SHALL then be zero.
REQ-015 Timers SHALL be down-counters saturating at zero: a grant loads the value_m1 (rrd on ACT/REF, ccd on RD/WR, rtw on RD, wtr on WR); value_m1=0 gives back-to-back issue.
REQ-016 tFAW: four slot counters; an ACT loads t_faw_m1 into the lowest-index zero slot; faw_ok = at least one slot zero; a load in the same cycle a slot reaches zero SHALL use the reloading slot.
REQ-017 Timer load and decrement in the same cycle: load SHALL win.
REQ-018 Requests deasserting while their pointer is advanced SHALL not affect arbitration beyond the current cycle; a request with no grant SHALL hold no state.
REQ-019 Timing inputs SHALL be sampled only at load time; changes mid-count SHALL not alter running counters.

Reset
REQ-020 While rst=1: all grants 0, cmd_valid 0, cmd_* 0, all timers and FAW slots 0, ptrs BK_CNT-1.
REQ-021 Reset asserted mid-operation SHALL clear state asynchronously; first grant possible in the first clock edge after rst deasserts.

Structure
REQ-022 sal_sched_pkg SHALL hold cmd_t (CMD_NOP=0, ACT, RD, WR, PRE, REF) and class index constants.
REQ-023 One sub-module sal_rr_arb (parameter N; req, ptr in; gnt one-hot, gnt_idx, any out), instantiated once per class.

Verification
REQ-024 BK_CNT=4, act_req=4'b1111 held, t_rrd_m1=0, t_faw_m1=15: ACT grants banks 0,1,2,3 on consecutive cycles, then none until cycle 16 from first ACT.
REQ-025 rd_req=4'b0101 held, t_ccd_m1=1, t_wtr_m1=0: rd_gnt alternates bank 0, bank 2 every second cycle; cmd_ca/id/len match bank slice one cycle later.
REQ-026 act_req[1] and rd_req[3] same cycle, all timers zero: cas_first=0 grants ACT bank 1; cas_first=1 grants RD bank 3.
REQ-027 WR bank 0 then rd_req[0] with t_wtr_m1=3: rd_gnt no earlier than 4 cycles after wr_gnt; WR after RD with t_rtw_m1=2 blocked 3 cycles.
REQ-028 Raise rst for one cycle during active tFAW/tCCD countdown: outputs zero immediately; after release act_req[2] granted at first edge, search starting at bank 0.

Source files
------------

// File: rtl/sal_sched_pkg.sv
// Shared types for the round-robin DRAM command scheduler.
// Holds the issued-command encoding, the arbitration class indices and
// the class-to-command mapping used by the top level.
package sal_sched_pkg;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_t;

    typedef logic [2:0] cls_t;

    localparam int unsigned NUM_CLS   = 5;
    localparam int unsigned FAW_SLOTS = 4;

    localparam cls_t CLS_ACT = 3'd0;
    localparam cls_t CLS_RD  = 3'd1;
    localparam cls_t CLS_WR  = 3'd2;
    localparam cls_t CLS_PRE = 3'd3;
    localparam cls_t CLS_REF = 3'd4;

    // Map an arbitration class to the command it issues.
    function automatic cmd_t cls_to_cmd(input cls_t cls);
        cmd_t c;
        case (cls)
            CLS_ACT: c = CMD_ACT;
            CLS_RD:  c = CMD_RD;
            CLS_WR:  c = CMD_WR;
            CLS_PRE: c = CMD_PRE;
            CLS_REF: c = CMD_REF;
            default: c = CMD_NOP;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sal_rr_arb.sv
// Combinational round-robin arbiter.
// Ports: req  - request vector
//        ptr  - last granted index; search starts at ptr+1 (mod N)
//        gnt  - one-hot grant
//        gnt_idx - index of the granted request
//        any  - at least one request present
module sal_rr_arb #(
    parameter int unsigned  N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int unsigned k;

    // First requester found walking forward from ptr+1, wrapping at N.
    always_comb begin
        any     = 1'b0;
        gnt_idx = '0;
        k       = 0;
        for (int unsigned i = 1; i <= N; i++) begin
            k = (32'(ptr) + i) % N;
            if (!any && req[IW'(k)]) begin
                any     = 1'b1;
                gnt_idx = IW'(k);
            end
        end
        gnt = N'(any) << gnt_idx;
    end

endmodule

// File: rtl/sal_sched_rr.sv
// DRAM command scheduler: per-class round-robin over banks, fixed class
// priority (selectable CAS-first), tRRD/tCCD/tRTW/tWTR/tFAW enforcement.
// Ports: clk, rst (async active-high)
//        *_req      - per-bank requests for ACT/RD/WR/PRE/REF
//        *_arr      - per-bank packed ra/ca/id/len fields, bank i at slice i
//        *_gnt      - combinational one-hot grants (at most one bit overall)
//        cmd_*      - registered issued command, zero when cmd_valid=0
//        t_*_m1     - timing values minus one, sampled when a timer loads
//        cas_first  - 1: RD > WR > ACT > PRE > REF, 0: ACT > RD > WR > PRE > REF
module sal_sched_rr
    import sal_sched_pkg::*;
#(
    parameter int unsigned  BK_CNT = 16,
    parameter int unsigned  RA_W   = 16,
    parameter int unsigned  CA_W   = 10,
    parameter int unsigned  ID_W   = 4,
    parameter int unsigned  LEN_W  = 4,
    parameter int unsigned  TW     = 6,
    localparam int unsigned BW     = (BK_CNT > 1) ? $clog2(BK_CNT) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BK_CNT-1:0]       act_req,
    input  logic [BK_CNT-1:0]       rd_req,
    input  logic [BK_CNT-1:0]       wr_req,
    input  logic [BK_CNT-1:0]       pre_req,
    input  logic [BK_CNT-1:0]       ref_req,
    input  logic [BK_CNT*RA_W-1:0]  ra_arr,
    input  logic [BK_CNT*CA_W-1:0]  ca_arr,
    input  logic [BK_CNT*ID_W-1:0]  id_arr,
    input  logic [BK_CNT*LEN_W-1:0] len_arr,
    output logic [BK_CNT-1:0]       act_gnt,
    output logic [BK_CNT-1:0]       rd_gnt,
    output logic [BK_CNT-1:0]       wr_gnt,
    output logic [BK_CNT-1:0]       pre_gnt,
    output logic [BK_CNT-1:0]       ref_gnt,
    output logic                    cmd_valid,
    output cmd_t                    cmd_type,
    output logic [BW-1:0]           cmd_ba,
    output logic [RA_W-1:0]         cmd_ra,
    output logic [CA_W-1:0]         cmd_ca,
    output logic [ID_W-1:0]         cmd_id,
    output logic [LEN_W-1:0]        cmd_len,
    input  logic [TW-1:0]           t_rrd_m1,
    input  logic [TW-1:0]           t_ccd_m1,
    input  logic [TW-1:0]           t_rtw_m1,
    input  logic [TW-1:0]           t_wtr_m1,
    input  logic [TW-1:0]           t_faw_m1,
    input  logic                    cas_first
);

    // Per-bank field views.
    logic [RA_W-1:0]  ra_b  [BK_CNT];
    logic [CA_W-1:0]  ca_b  [BK_CNT];
    logic [ID_W-1:0]  id_b  [BK_CNT];
    logic [LEN_W-1:0] len_b [BK_CNT];

    for (genvar b = 0; b < BK_CNT; b++) begin : g_unpack
        assign ra_b[b]  = ra_arr[b*RA_W +: RA_W];
        assign ca_b[b]  = ca_arr[b*CA_W +: CA_W];
        assign id_b[b]  = id_arr[b*ID_W +: ID_W];
        assign len_b[b] = len_arr[b*LEN_W +: LEN_W];
    end

    // Timer and pointer state.
    logic [TW-1:0]    rrd_q, ccd_q, rtw_q, wtr_q;
    logic [TW-1:0]    faw_q [FAW_SLOTS];
    logic [BW-1:0]    ptr_q [NUM_CLS];

    // Arbitration signals.
    logic [BK_CNT-1:0]    cls_req [NUM_CLS];
    logic [BK_CNT-1:0]    arb_req [NUM_CLS];
    logic [BK_CNT-1:0]    arb_gnt [NUM_CLS];
    logic [BW-1:0]        arb_idx [NUM_CLS];
    logic [NUM_CLS-1:0]   arb_any;
    logic [NUM_CLS-1:0]   elig;
    logic [NUM_CLS-1:0]   win_hot;
    logic [FAW_SLOTS-1:0] faw_ld;
    logic                 faw_ok;
    logic                 win_any;
    cls_t                 win_cls;
    logic [BW-1:0]        win_bank;

    // Registered-command next values.
    logic                 cmd_valid_d;
    cmd_t                 cmd_type_d;
    logic [BW-1:0]        cmd_ba_d;
    logic [RA_W-1:0]      cmd_ra_d;
    logic [CA_W-1:0]      cmd_ca_d;
    logic [ID_W-1:0]      cmd_id_d;
    logic [LEN_W-1:0]     cmd_len_d;

    // Load wins over decrement; idle timers saturate at zero.
    function automatic logic [TW-1:0] tmr_next(input logic ld, input logic [TW-1:0] val,
                                               input logic [TW-1:0] cur);
        if (ld)
            return val;
        else if (cur != '0)
            return cur - TW'(1);
        else
            return cur;
    endfunction

    // FAW: ACT allowed while any slot is free; an ACT takes the lowest free slot.
    always_comb begin
        faw_ok = 1'b0;
        faw_ld = '0;
        for (int s = 0; s < int'(FAW_SLOTS); s++) begin
            if (!faw_ok && faw_q[s] == '0) begin
                faw_ok    = 1'b1;
                faw_ld[s] = win_hot[CLS_ACT];
            end
        end
    end

    // Class requests and timing eligibility.
    always_comb begin
        cls_req[CLS_ACT] = act_req;
        cls_req[CLS_RD]  = rd_req;
        cls_req[CLS_WR]  = wr_req;
        cls_req[CLS_PRE] = pre_req;
        cls_req[CLS_REF] = ref_req;
        elig             = '0;
        elig[CLS_ACT]    = (rrd_q == '0) && faw_ok;
        elig[CLS_RD]     = (ccd_q == '0) && (wtr_q == '0);
        elig[CLS_WR]     = (ccd_q == '0) && (rtw_q == '0);
        elig[CLS_PRE]    = 1'b1;
        elig[CLS_REF]    = (rrd_q == '0);
    end

    // One arbiter per class; ineligible classes present no requests.
    for (genvar c = 0; c < NUM_CLS; c++) begin : g_arb
        assign arb_req[c] = cls_req[c] & {BK_CNT{elig[c]}};
        sal_rr_arb #(.N(BK_CNT)) u_arb (
            .req     (arb_req[c]),
            .ptr     (ptr_q[c]),
            .gnt     (arb_gnt[c]),
            .gnt_idx (arb_idx[c]),
            .any     (arb_any[c])
        );
    end

    // Class priority; grants are held off entirely during reset.
    always_comb begin
        win_cls = CLS_ACT;
        win_any = !rst && (arb_any != '0);
        if (cas_first && arb_any[CLS_RD])      win_cls = CLS_RD;
        else if (cas_first && arb_any[CLS_WR]) win_cls = CLS_WR;
        else if (arb_any[CLS_ACT])             win_cls = CLS_ACT;
        else if (arb_any[CLS_RD])              win_cls = CLS_RD;
        else if (arb_any[CLS_WR])              win_cls = CLS_WR;
        else if (arb_any[CLS_PRE])             win_cls = CLS_PRE;
        else                                   win_cls = CLS_REF;
        for (int c = 0; c < int'(NUM_CLS); c++)
            win_hot[c] = win_any && (win_cls == cls_t'(c));
        win_bank = arb_idx[win_cls];
    end

    assign act_gnt = win_hot[CLS_ACT] ? arb_gnt[CLS_ACT] : '0;
    assign rd_gnt  = win_hot[CLS_RD]  ? arb_gnt[CLS_RD]  : '0;
    assign wr_gnt  = win_hot[CLS_WR]  ? arb_gnt[CLS_WR]  : '0;
    assign pre_gnt = win_hot[CLS_PRE] ? arb_gnt[CLS_PRE] : '0;
    assign ref_gnt = win_hot[CLS_REF] ? arb_gnt[CLS_REF] : '0;

    // Command payload: row for ACT, column/id/len for CAS, zero otherwise.
    always_comb begin
        cmd_valid_d = win_any;
        cmd_type_d  = win_any ? cls_to_cmd(win_cls) : CMD_NOP;
        cmd_ba_d    = win_any ? win_bank : '0;
        cmd_ra_d    = '0;
        cmd_ca_d    = '0;
        cmd_id_d    = '0;
        cmd_len_d   = '0;
        if (win_hot[CLS_ACT])
            cmd_ra_d = ra_b[win_bank];
        if (win_hot[CLS_RD] || win_hot[CLS_WR]) begin
            cmd_ca_d  = ca_b[win_bank];
            cmd_id_d  = id_b[win_bank];
            cmd_len_d = len_b[win_bank];
        end
    end

    // Timers and round-robin pointers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rrd_q <= '0;
            ccd_q <= '0;
            rtw_q <= '0;
            wtr_q <= '0;
            for (int s = 0; s < int'(FAW_SLOTS); s++)
                faw_q[s] <= '0;
            for (int c = 0; c < int'(NUM_CLS); c++)
                ptr_q[c] <= BW'(BK_CNT - 1);
        end else begin
            rrd_q <= tmr_next(win_hot[CLS_ACT] || win_hot[CLS_REF], t_rrd_m1, rrd_q);
            ccd_q <= tmr_next(win_hot[CLS_RD] || win_hot[CLS_WR], t_ccd_m1, ccd_q);
            rtw_q <= tmr_next(win_hot[CLS_RD], t_rtw_m1, rtw_q);
            wtr_q <= tmr_next(win_hot[CLS_WR], t_wtr_m1, wtr_q);
            for (int s = 0; s < int'(FAW_SLOTS); s++)
                faw_q[s] <= tmr_next(faw_ld[s], t_faw_m1, faw_q[s]);
            for (int c = 0; c < int'(NUM_CLS); c++)
                if (win_hot[c])
                    ptr_q[c] <= arb_idx[c];
        end
    end

    // Issued command register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_type  <= CMD_NOP;
            cmd_ba    <= '0;
            cmd_ra    <= '0;
            cmd_ca    <= '0;
            cmd_id    <= '0;
            cmd_len   <= '0;
        end else begin
            cmd_valid <= cmd_valid_d;
            cmd_type  <= cmd_type_d;
            cmd_ba    <= cmd_ba_d;
            cmd_ra    <= cmd_ra_d;
            cmd_ca    <= cmd_ca_d;
            cmd_id    <= cmd_id_d;
            cmd_len   <= cmd_len_d;
        end
    end

endmodule

// File: tb/tb_sal_sched_rr.sv
// Self-checking bench for sal_sched_rr with four banks: directed vector
// table, hand-written timing/reset sequences and a randomized run against
// a cycle-count based reference model.
module tb_sal_sched_rr;

    localparam int unsigned BK = 4;
    localparam int unsigned TW = 6;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [BK-1:0]     act_req, rd_req, wr_req, pre_req, ref_req;
    logic [BK*16-1:0]  ra_arr;
    logic [BK*10-1:0]  ca_arr;
    logic [BK*4-1:0]   id_arr;
    logic [BK*4-1:0]   len_arr;
    logic [BK-1:0]     act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt;
    logic              cmd_valid;
    logic [2:0]        cmd_type;
    logic [1:0]        cmd_ba;
    logic [15:0]       cmd_ra;
    logic [9:0]        cmd_ca;
    logic [3:0]        cmd_id, cmd_len;
    logic [TW-1:0]     t_rrd_m1, t_ccd_m1, t_rtw_m1, t_wtr_m1, t_faw_m1;
    logic              cas_first;

    int n_chk = 0;
    int n_err = 0;

    sal_sched_rr #(
        .BK_CNT(BK), .RA_W(16), .CA_W(10), .ID_W(4), .LEN_W(4), .TW(TW)
    ) dut (
        .clk(clk), .rst(rst),
        .act_req(act_req), .rd_req(rd_req), .wr_req(wr_req),
        .pre_req(pre_req), .ref_req(ref_req),
        .ra_arr(ra_arr), .ca_arr(ca_arr), .id_arr(id_arr), .len_arr(len_arr),
        .act_gnt(act_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .pre_gnt(pre_gnt), .ref_gnt(ref_gnt),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_ba(cmd_ba),
        .cmd_ra(cmd_ra), .cmd_ca(cmd_ca), .cmd_id(cmd_id), .cmd_len(cmd_len),
        .t_rrd_m1(t_rrd_m1), .t_ccd_m1(t_ccd_m1), .t_rtw_m1(t_rtw_m1),
        .t_wtr_m1(t_wtr_m1), .t_faw_m1(t_faw_m1), .cas_first(cas_first)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, r, w, p, f;
        logic       cas;
        logic [3:0] ea, er, ew, ep, ef;
    } vec_t;

    vec_t vt[10];

    // Reference model state (absolute cycle numbers).
    int unsigned now, rrd_rdy, ccd_rdy, rtw_rdy, wtr_rdy;
    int unsigned faw_win[$];
    int unsigned faw_tmp[$];
    int          last_b[5];
    logic [3:0]  rq[5];
    bit          el[5];
    int          ord[5];
    int          wc, wb;
    logic [63:0] exp_g, exp_c;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] gvec();
        return 64'({act_gnt, rd_gnt, wr_gnt, pre_gnt, ref_gnt});
    endfunction

    function automatic logic [63:0] cmdv();
        return 64'({cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len});
    endfunction

    function automatic logic [63:0] mk_cmd(input logic v, input logic [2:0] t, input logic [1:0] ba,
                                           input logic [15:0] ra, input logic [9:0] ca,
                                           input logic [3:0] id, input logic [3:0] ln);
        return 64'({v, t, ba, ra, ca, id, ln});
    endfunction

    function automatic logic [15:0] fra(input int b); return ra_arr[b*16 +: 16]; endfunction
    function automatic logic [9:0]  fca(input int b); return ca_arr[b*10 +: 10]; endfunction
    function automatic logic [3:0]  fid(input int b); return id_arr[b*4 +: 4];   endfunction
    function automatic logic [3:0]  fln(input int b); return len_arr[b*4 +: 4];  endfunction

    // Expected {valid,type,bank} following a table vector's grant.
    function automatic logic [63:0] vcmd(input vec_t v);
        logic [3:0] g[5];
        int         idx;
        g[0] = v.ea; g[1] = v.er; g[2] = v.ew; g[3] = v.ep; g[4] = v.ef;
        for (int c = 0; c < 5; c++) begin
            if (g[c] != 4'b0) begin
                idx = 0;
                for (int j = 3; j >= 0; j--) if (g[c][j]) idx = j;
                return 64'({1'b1, 3'(c + 1), 2'(idx)});
            end
        end
        return 64'(0);
    endfunction

    task automatic clr_in();
        act_req = '0; rd_req = '0; wr_req = '0; pre_req = '0; ref_req = '0;
        t_rrd_m1 = '0; t_ccd_m1 = '0; t_rtw_m1 = '0; t_wtr_m1 = '0; t_faw_m1 = '0;
        cas_first = 1'b0;
    endtask

    task automatic set_fields();
        for (int i = 0; i < int'(BK); i++) begin
            ra_arr[i*16 +: 16] = 16'hA000 + 16'(i * 16'h111);
            ca_arr[i*10 +: 10] = 10'h040 + 10'(i * 3);
            id_arr[i*4 +: 4]   = 4'(i + 5);
            len_arr[i*4 +: 4]  = 4'(i * 2 + 1);
        end
    endtask

    // Leaves the bench at a negedge with rst just released.
    task automatic do_reset();
        rst = 1'b1;
        clr_in();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        logic [3:0] exp_rd[8];
        logic [3:0] exp_wr[8];

        clr_in();
        set_fields();

        // Directed single-cycle vectors, each from a fresh reset.
        vt[0] = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[1] = '{4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000};
        vt[2] = '{4'b0000, 4'b0000, 4'b0000, 4'b0110, 4'b1111, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000};
        vt[3] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100};
        vt[4] = '{4'b0000, 4'b0000, 4'b1010, 4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000};
        vt[5] = '{4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000};
        vt[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[7] = '{4'b1100, 4'b0011, 4'b1111, 4'b0000, 4'b0000, 1'b0, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        vt[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        vt[9] = '{4'b0001, 4'b0000, 4'b0100, 4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b0000};

        // Reset state: outputs idle.
        @(negedge clk);
        act_req = 4'hF; rd_req = 4'hF;
        #1;
        chk("rst_gnt", gvec(), 64'(0));
        chk("rst_cmd", cmdv(), 64'(0));

        foreach (vt[i]) begin
            do_reset();
            act_req = vt[i].a; rd_req = vt[i].r; wr_req = vt[i].w;
            pre_req = vt[i].p; ref_req = vt[i].f; cas_first = vt[i].cas;
            #1;
            chk($sformatf("tbl%0d_gnt", i), gvec(),
                64'({vt[i].ea, vt[i].er, vt[i].ew, vt[i].ep, vt[i].ef}));
            @(negedge clk);
            chk($sformatf("tbl%0d_cmd", i), 64'({cmd_valid, cmd_type, cmd_ba}), vcmd(vt[i]));
        end

        // Four ACTs back to back, then the tFAW window holds until cycle 16.
        do_reset();
        t_faw_m1 = TW'(15);
        act_req  = 4'hF;
        for (int k = 0; k <= 16; k++) begin
            #1;
            e = (k < 4) ? 4'(1 << k) : ((k == 16) ? 4'b0001 : 4'b0000);
            chk($sformatf("faw_c%0d", k), 64'(act_gnt), 64'(e));
            @(negedge clk);
        end

        // RD alternating between banks 0 and 2 with tCCD of two cycles.
        do_reset();
        t_ccd_m1 = TW'(1);
        rd_req   = 4'b0101;
        for (int k = 0; k < 6; k++) begin
            #1;
            e = ((k % 4) == 0) ? 4'b0001 : (((k % 4) == 2) ? 4'b0100 : 4'b0000);
            chk($sformatf("ccd_gnt%0d", k), gvec(), 64'({4'b0, e, 12'b0}));
            if (k % 2 == 1)
                chk($sformatf("ccd_cmd%0d", k), cmdv(),
                    mk_cmd(1'b1, 3'd2, 2'((k % 4) == 1 ? 0 : 2), 16'h0,
                           fca((k % 4) == 1 ? 0 : 2), fid((k % 4) == 1 ? 0 : 2),
                           fln((k % 4) == 1 ? 0 : 2)));
            else if (k > 0)
                chk($sformatf("ccd_cmd%0d", k), cmdv(), 64'(0));
            @(negedge clk);
        end

        // WR->RD blocked by tWTR, then RD->WR blocked by tRTW.
        do_reset();
        t_wtr_m1 = TW'(3);
        t_rtw_m1 = TW'(2);
        exp_rd = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        exp_wr = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001};
        for (int k = 0; k < 8; k++) begin
            wr_req = (k == 0 || k >= 5) ? 4'b0001 : 4'b0000;
            rd_req = (k >= 1 && k <= 4) ? 4'b0001 : 4'b0000;
            #1;
            chk($sformatf("turn_c%0d", k), gvec(), 64'({4'b0, exp_rd[k], exp_wr[k], 8'b0}));
            @(negedge clk);
        end

        // Reset in the middle of active tRRD/tCCD/tFAW countdowns.
        do_reset();
        t_rrd_m1 = TW'(7);
        t_ccd_m1 = TW'(7);
        t_faw_m1 = TW'(15);
        act_req  = 4'b0001;
        #1;
        chk("mrst_act0", gvec(), 64'({4'b0001, 16'b0}));
        @(negedge clk);
        act_req = 4'b0000;
        rd_req  = 4'b0001;
        #1;
        chk("mrst_rd", gvec(), 64'({4'b0, 4'b0001, 12'b0}));
        @(negedge clk);
        #1;
        chk("mrst_ccd_block", gvec(), 64'(0));
        chk("mrst_cmd_pre", cmdv(), mk_cmd(1'b1, 3'd2, 2'd0, 16'h0, fca(0), fid(0), fln(0)));
        rst     = 1'b1;
        act_req = 4'b0100;
        #1;
        chk("mrst_gnt_in_rst", gvec(), 64'(0));
        chk("mrst_cmd_in_rst", cmdv(), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_act_after", gvec(), 64'({4'b0100, 16'b0}));
        @(negedge clk);
        chk("mrst_cmd_after", cmdv(), mk_cmd(1'b1, 3'd1, 2'd2, fra(2), 10'h0, 4'h0, 4'h0));

        // Randomized run against the reference model.
        do_reset();
        for (int c = 0; c < 5; c++) last_b[c] = 3;
        now = 0; rrd_rdy = 0; ccd_rdy = 0; rtw_rdy = 0; wtr_rdy = 0;
        faw_win.delete();
        exp_c = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_cmd", cmdv(), exp_c);
            if (cyc % 64 == 0) begin
                t_rrd_m1 = TW'($urandom_range(0, 3));
                t_ccd_m1 = TW'($urandom_range(0, 3));
                t_rtw_m1 = TW'($urandom_range(0, 4));
                t_wtr_m1 = TW'($urandom_range(0, 4));
                t_faw_m1 = TW'($urandom_range(0, 20));
            end
            if (cyc % 16 == 0) cas_first = 1'($urandom_range(0, 1));
            act_req = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            rd_req  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            wr_req  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            pre_req = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            ref_req = 4'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15));
            ra_arr  = {$urandom(), $urandom()};
            ca_arr  = 40'({$urandom(), $urandom()});
            id_arr  = 16'($urandom());
            len_arr = 16'($urandom());
            #1;

            rq[0] = act_req; rq[1] = rd_req; rq[2] = wr_req; rq[3] = pre_req; rq[4] = ref_req;
            faw_tmp.delete();
            foreach (faw_win[i]) if (faw_win[i] > now) faw_tmp.push_back(faw_win[i]);
            faw_win = faw_tmp;
            el[0] = (now >= rrd_rdy) && (faw_win.size() < 4);
            el[1] = (now >= ccd_rdy) && (now >= wtr_rdy);
            el[2] = (now >= ccd_rdy) && (now >= rtw_rdy);
            el[3] = 1'b1;
            el[4] = (now >= rrd_rdy);
            if (cas_first) ord = '{1, 2, 0, 3, 4};
            else           ord = '{0, 1, 2, 3, 4};
            wc = -1; wb = 0;
            for (int p = 0; p < 5; p++) begin
                if (wc < 0 && el[ord[p]] && rq[ord[p]] != 4'b0) begin
                    wc = ord[p];
                    for (int j = 4; j >= 1; j--)
                        if (rq[wc][(last_b[wc] + j) % 4]) wb = (last_b[wc] + j) % 4;
                end
            end
            exp_g = '0;
            exp_c = '0;
            if (wc >= 0) begin
                exp_g[(4 - wc) * 4 + wb] = 1'b1;
                exp_c = mk_cmd(1'b1, 3'(wc + 1), 2'(wb),
                               (wc == 0) ? fra(wb) : 16'h0,
                               (wc == 1 || wc == 2) ? fca(wb) : 10'h0,
                               (wc == 1 || wc == 2) ? fid(wb) : 4'h0,
                               (wc == 1 || wc == 2) ? fln(wb) : 4'h0);
                last_b[wc] = wb;
                case (wc)
                    0: begin
                        rrd_rdy = now + 32'(t_rrd_m1) + 1;
                        faw_win.push_back(now + 32'(t_faw_m1) + 1);
                    end
                    1: begin
                        ccd_rdy = now + 32'(t_ccd_m1) + 1;
                        rtw_rdy = now + 32'(t_rtw_m1) + 1;
                    end
                    2: begin
                        ccd_rdy = now + 32'(t_ccd_m1) + 1;
                        wtr_rdy = now + 32'(t_wtr_m1) + 1;
                    end
                    4: rrd_rdy = now + 32'(t_rrd_m1) + 1;
                    default: ;
                endcase
            end
            chk("rnd_gnt", gvec(), exp_g);
            now++;
            @(negedge clk);
        end
        chk("rnd_cmd_last", cmdv(), exp_c);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
